// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotation sequencer.
// Angles and vectors are signed Q2.30.
package cordic_pkg;

  localparam int ITERS_MAX = 32;
  localparam int FRAC_BITS = 30;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SHX  = 3'd1,
    ST_SHY  = 3'd2,
    ST_UPD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // round(atan(2^-i) * 2^30)
  function automatic logic [31:0] atan_lookup(input logic [4:0] idx);
    logic [31:0] val;
    case (idx)
      5'd0:  val = 32'h3243_F6A9;
      5'd1:  val = 32'h1DAC_6705;
      5'd2:  val = 32'h0FAD_BAFD;
      5'd3:  val = 32'h07F5_6EA7;
      5'd4:  val = 32'h03FE_AB77;
      5'd5:  val = 32'h01FF_D55C;
      5'd6:  val = 32'h00FF_FAAB;
      5'd7:  val = 32'h007F_FF55;
      5'd8:  val = 32'h003F_FFEB;
      5'd9:  val = 32'h001F_FFFD;
      5'd10: val = 32'h0010_0000;
      5'd11: val = 32'h0008_0000;
      5'd12: val = 32'h0004_0000;
      5'd13: val = 32'h0002_0000;
      5'd14: val = 32'h0001_0000;
      5'd15: val = 32'h0000_8000;
      5'd16: val = 32'h0000_4000;
      5'd17: val = 32'h0000_2000;
      5'd18: val = 32'h0000_1000;
      5'd19: val = 32'h0000_0800;
      5'd20: val = 32'h0000_0400;
      5'd21: val = 32'h0000_0200;
      5'd22: val = 32'h0000_0100;
      5'd23: val = 32'h0000_0080;
      5'd24: val = 32'h0000_0040;
      5'd25: val = 32'h0000_0020;
      5'd26: val = 32'h0000_0010;
      5'd27: val = 32'h0000_0008;
      5'd28: val = 32'h0000_0004;
      5'd29: val = 32'h0000_0002;
      5'd30: val = 32'h0000_0001;
      default: val = 32'h0000_0000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_sign_fill.sv
// Turns the shared logical right shifter's result into an arithmetic shift
// by filling the vacated upper bits with the operand's sign.
module cordic_sign_fill (
  input  logic        msb,
  input  logic [4:0]  amount,
  input  logic [31:0] sh_result,
  output logic [31:0] filled
);

  assign filled = msb ? (sh_result | ~(32'hFFFF_FFFF >> amount)) : sh_result;

endmodule

// File: rtl/cordic_rot_sequencer.sv
// Iterative CORDIC rotation controller: per iteration it borrows the external
// shifter for X then Y, then applies the add/subtract update.
module cordic_rot_sequencer
  import cordic_pkg::*;
#(
  parameter int ITERS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] z_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out,
  output logic [31:0] sh_data,
  output logic        sh_rightleft,
  output logic [4:0]  sh_amount,
  input  logic [31:0] sh_result,
  output state_t      state
);

  localparam logic [4:0] LAST = 5'(ITERS - 1);

  // Handshake: start is a level sampled only in IDLE; done is a single-cycle
  // pulse in DONE and x_out/y_out/z_out stay stable until the next accepted start.
  state_t      state_next;
  logic [31:0] x, y, z, xs, ys;
  logic [4:0]  i;
  logic        load, cap_x, cap_y, upd;
  logic        fill_msb;
  logic [31:0] filled;
  logic        z_pos;
  logic [31:0] atan_i;

  cordic_sign_fill u_sign_fill (
    .msb       (fill_msb),
    .amount    (sh_amount),
    .sh_result (sh_result),
    .filled    (filled)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    cap_x      = 1'b0;
    cap_y      = 1'b0;
    upd        = 1'b0;
    done       = 1'b0;
    busy       = (state != ST_IDLE);
    sh_data    = '0;
    sh_amount  = '0;
    fill_msb   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_SHX;
        end
      end
      ST_SHX: begin
        sh_data    = x;
        sh_amount  = i;
        fill_msb   = x[31];
        cap_x      = 1'b1;
        state_next = ST_SHY;
      end
      ST_SHY: begin
        sh_data    = y;
        sh_amount  = i;
        fill_msb   = y[31];
        cap_y      = 1'b1;
        state_next = ST_UPD;
      end
      ST_UPD: begin
        upd        = 1'b1;
        state_next = (i == LAST) ? ST_DONE : ST_SHX;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // z == 0 counts as non-negative, rotating in the +1 direction.
  assign z_pos  = ~z[31];
  assign atan_i = atan_lookup(i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      xs    <= '0;
      ys    <= '0;
      i     <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        x <= x_in;
        y <= y_in;
        z <= z_in;
        i <= '0;
      end
      if (cap_x) xs <= filled;
      if (cap_y) ys <= filled;
      if (upd) begin
        x <= z_pos ? (x - ys) : (x + ys);
        y <= z_pos ? (y + xs) : (y - xs);
        z <= z_pos ? (z - atan_i) : (z + atan_i);
        if (i != LAST) i <= i + 5'd1;
      end
    end
  end

  assign sh_rightleft = 1'b0;
  assign x_out        = x;
  assign y_out        = y;
  assign z_out        = z;

endmodule

// File: tb/tb_cordic_rot_sequencer.sv
// Bench for cordic_rot_sequencer: sign-fill vector table, reference-model
// rotations, and hand-written latency/reset/back-to-back sequences.
module tb_cordic_rot_sequencer;
  import cordic_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: ITERS=16
  logic        start_a = 1'b0;
  logic [31:0] x_in_a = '0, y_in_a = '0, z_in_a = '0;
  logic        busy_a, done_a, sh_rl_a;
  logic [31:0] x_out_a, y_out_a, z_out_a, sh_data_a, sh_res_a;
  logic [4:0]  sh_amt_a;
  state_t      state_a;
  assign sh_res_a = sh_rl_a ? (sh_data_a << sh_amt_a) : (sh_data_a >> sh_amt_a);

  cordic_rot_sequencer #(.ITERS(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .x_in(x_in_a), .y_in(y_in_a), .z_in(z_in_a),
    .busy(busy_a), .done(done_a),
    .x_out(x_out_a), .y_out(y_out_a), .z_out(z_out_a),
    .sh_data(sh_data_a), .sh_rightleft(sh_rl_a), .sh_amount(sh_amt_a),
    .sh_result(sh_res_a), .state(state_a)
  );

  // DUT B: ITERS=1
  logic        start_b = 1'b0;
  logic [31:0] x_in_b = '0, y_in_b = '0, z_in_b = '0;
  logic        busy_b, done_b, sh_rl_b;
  logic [31:0] x_out_b, y_out_b, z_out_b, sh_data_b, sh_res_b;
  logic [4:0]  sh_amt_b;
  state_t      state_b;
  assign sh_res_b = sh_rl_b ? (sh_data_b << sh_amt_b) : (sh_data_b >> sh_amt_b);

  cordic_rot_sequencer #(.ITERS(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .x_in(x_in_b), .y_in(y_in_b), .z_in(z_in_b),
    .busy(busy_b), .done(done_b),
    .x_out(x_out_b), .y_out(y_out_b), .z_out(z_out_b),
    .sh_data(sh_data_b), .sh_rightleft(sh_rl_b), .sh_amount(sh_amt_b),
    .sh_result(sh_res_b), .state(state_b)
  );

  // standalone sign-fill instance for the vector table
  logic        sf_msb = 1'b0;
  logic [4:0]  sf_amt = '0;
  logic [31:0] sf_res = '0, sf_out;
  cordic_sign_fill u_sf (.msb(sf_msb), .amount(sf_amt), .sh_result(sf_res), .filled(sf_out));

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: plain arithmetic from the rotation rules
  typedef struct {
    logic [31:0] x, y, z, ys2;
    logic [31:0] xi[32];
    logic [31:0] yi[32];
  } res_t;

  function automatic logic [31:0] atan_ref(input int k);
    real r;
    r = $atan($pow(2.0, -1.0 * k)) * $pow(2.0, 30.0);
    return 32'($rtoi(r + 0.5));
  endfunction

  function automatic res_t model(input logic [31:0] x0, y0, z0, input int n);
    logic signed [31:0] x, y, z, xs, ys;
    res_t r;
    x = x0; y = y0; z = z0; r.ys2 = '0;
    for (int k = 0; k < 32; k++) begin r.xi[k] = '0; r.yi[k] = '0; end
    for (int k = 0; k < n; k++) begin
      r.xi[k] = x;
      r.yi[k] = y;
      xs = x >>> k;
      ys = y >>> k;
      if (k == 2) r.ys2 = ys;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - atan_ref(k);
      end else begin
        x = x + ys; y = y - xs; z = z + atan_ref(k);
      end
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  // driver: one rotation on DUT A, checked against the model
  task automatic run_a(input logic [31:0] xi, yi, zi, input string tag,
                       input bit check_seq, input int extra_start,
                       output logic [31:0] rx, ry, rz);
    res_t m;
    int done_cnt, done_at, it, ph;
    logic busy_last, busy_after;
    m = model(xi, yi, zi, 16);
    @(negedge clk);
    x_in_a = xi; y_in_a = yi; z_in_a = zi; start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    done_cnt = 0; done_at = -1; busy_last = 1'b0; busy_after = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_a) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (k == 49) busy_last = busy_a;
      if (k == 50) busy_after = busy_a;
      if (check_seq && k <= 48) begin
        it = (k - 1) / 3;
        ph = (k - 1) % 3;
        check({tag, "_sh_amount"}, 64'(sh_amt_a), (ph == 2) ? 64'd0 : 64'(it));
        check({tag, "_sh_data"}, 64'(sh_data_a),
              (ph == 0) ? 64'(m.xi[it]) : (ph == 1) ? 64'(m.yi[it]) : 64'd0);
        check({tag, "_sh_rightleft"}, 64'(sh_rl_a), 64'd0);
        if (k == 9) check({tag, "_ys_i2"}, 64'(u_dut_a.ys), 64'(m.ys2));
      end
      if (extra_start > 0 && k == extra_start) start_a = 1'b1;
      else if (extra_start > 0 && k == extra_start + 1) start_a = 1'b0;
    end
    start_a = 1'b0;
    check({tag, "_done_cycle"}, 64'(done_at), 64'd49);
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_before_done"}, 64'(busy_last), 64'd1);
    check({tag, "_busy_after_done"}, 64'(busy_after), 64'd0);
    check({tag, "_x_out"}, 64'(x_out_a), 64'(m.x));
    check({tag, "_y_out"}, 64'(y_out_a), 64'(m.y));
    check({tag, "_z_out"}, 64'(z_out_a), 64'(m.z));
    rx = x_out_a; ry = y_out_a; rz = z_out_a;
  endtask

  function automatic logic [31:0] absdiff(input logic [31:0] a, b);
    logic signed [31:0] d;
    d = a - b;
    return (d < 0) ? -d : d;
  endfunction

  typedef struct {
    logic        msb;
    logic [4:0]  amt;
    logic [31:0] res;
    logic [31:0] exp;
  } sf_vec_t;

  sf_vec_t sf_tab[6];

  initial begin
    logic [31:0] rx, ry, rz, qx, qy, qz, sx, sy, sz;
    res_t mb;
    int done_at, b2b_done[$], low_between;
    sf_tab[0] = '{1'b1, 5'd2,  32'h3000_0000, 32'hF000_0000};
    sf_tab[1] = '{1'b0, 5'd2,  32'h3000_0000, 32'h3000_0000};
    sf_tab[2] = '{1'b1, 5'd0,  32'h8000_0000, 32'h8000_0000};
    sf_tab[3] = '{1'b1, 5'd31, 32'h0000_0001, 32'hFFFF_FFFF};
    sf_tab[4] = '{1'b1, 5'd16, 32'h0000_ABCD, 32'hFFFF_ABCD};
    sf_tab[5] = '{1'b0, 5'd31, 32'h0000_0001, 32'h0000_0001};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_outs_a", {x_out_a, y_out_a ^ z_out_a}, 64'd0);
    check("rst_sh_a", {sh_data_a, 27'd0, sh_amt_a}, 64'd0);
    check("rst_rl_a", 64'(sh_rl_a), 64'd0);
    check("rst_state_a", 64'(state_a), 64'(ST_IDLE));
    check("rst_busy_b", 64'(busy_b), 64'd0);
    rst = 1'b0;

    // sign-fill vector table
    for (int t = 0; t < 6; t++) begin
      sf_msb = sf_tab[t].msb; sf_amt = sf_tab[t].amt; sf_res = sf_tab[t].res;
      #1;
      check($sformatf("sign_fill_%0d", t), 64'(sf_out), 64'(sf_tab[t].exp));
    end

    // quarter-pi rotation
    run_a(32'h26DD_3B6A, 32'h0, 32'h3243_F6A9, "qpi", 1'b0, 0, qx, qy, qz);
    check("qpi_x_window", 64'(absdiff(qx, 32'h2D41_3CCD) <= 32'h2_0000), 64'd1);
    check("qpi_y_window", 64'(absdiff(qy, 32'h2D41_3CCD) <= 32'h2_0000), 64'd1);
    check("qpi_z_small", 64'(absdiff(qz, 32'h0) < 32'h2_0000), 64'd1);

    // shifter sequence and sign fill with negative Y
    run_a(32'h1234_5678, 32'hC000_0000, 32'h1000_0000, "shseq", 1'b1, 0, sx, sy, sz);

    // start while busy: second pulse in iteration 3
    run_a(32'h26DD_3B6A, 32'h0, 32'h3243_F6A9, "dblstart", 1'b0, 10, rx, ry, rz);
    check("dblstart_same_result", {rx, ry ^ rz}, {qx, qy ^ qz});

    // reset mid-operation (iteration 5)
    @(negedge clk);
    x_in_a = 32'h3000_0000; y_in_a = 32'h1000_0000; z_in_a = 32'h2000_0000; start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_done", 64'(done_a), 64'd0);
    check("midrst_outs", {x_out_a | y_out_a | z_out_a, 32'd0}, 64'd0);
    check("midrst_sh", {sh_data_a, 27'd0, sh_amt_a}, 64'd0);
    check("midrst_state", 64'(state_a), 64'(ST_IDLE));
    rst = 1'b0;
    run_a(32'h3000_0000, 32'h1000_0000, 32'h2000_0000, "postrst", 1'b0, 0, rx, ry, rz);

    // randomized rotations
    for (int r = 0; r < 6; r++)
      run_a($urandom, $urandom, $urandom, $sformatf("rand%0d", r), (r < 2), 0, rx, ry, rz);

    // ITERS=1 boundary
    mb = model(32'h4000_0000, 32'h0, 32'h0, 1);
    @(negedge clk);
    x_in_b = 32'h4000_0000; y_in_b = 32'h0; z_in_b = 32'h0; start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done_b && done_at < 0) done_at = k;
    end
    check("it1_done_cycle", 64'(done_at), 64'd4);
    check("it1_x_out", 64'(x_out_b), 64'h4000_0000);
    check("it1_y_out", 64'(y_out_b), 64'h4000_0000);
    check("it1_z_out", 64'(z_out_b), 64'hCDBC_0957);
    check("it1_model", {x_out_b, z_out_b}, {mb.x, mb.z});

    // back-to-back with start held high
    @(negedge clk);
    x_in_a = 32'h26DD_3B6A; y_in_a = 32'h0; z_in_a = 32'h3243_F6A9; start_a = 1'b1;
    low_between = 0;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (done_a) b2b_done.push_back(k);
      if (!busy_a && b2b_done.size() == 1) low_between++;
    end
    start_a = 1'b0;
    check("b2b_done_count", 64'(b2b_done.size()), 64'd3);
    if (b2b_done.size() >= 3) begin
      check("b2b_first_done", 64'(b2b_done[0]), 64'd49);
      check("b2b_spacing_1", 64'(b2b_done[1] - b2b_done[0]), 64'd50);
      check("b2b_spacing_2", 64'(b2b_done[2] - b2b_done[1]), 64'd50);
    end
    check("b2b_busy_low", 64'(low_between), 64'd1);
    repeat (60) @(negedge clk);
    check("b2b_result", {x_out_a, y_out_a ^ z_out_a}, {qx, qy ^ qz});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
